// File: rtl/hs_token_sink_pkg.sv
// Shared types and constants for the hs_token_sink handshake receiver.
// Holds the FSM state type, the idle/ready levels of the handshake wires and the default sizes.
package ddp_hs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPT     = 2'd1,
    WAIT_RTZ = 2'd2,
    HOLD     = 2'd3
  } hs_state_t;

  localparam logic SEND_IDLE      = 1'b1;
  localparam logic ACK_READY      = 1'b1;
  localparam int   DEFAULT_DATA_W = 16;
  localparam int   DEFAULT_DEPTH  = 4;

  // One extra pointer bit distinguishes full from empty when the index bits match.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs_token_sink_if.sv
// Handshake and stream bundle for hs_token_sink: async Send/Ack/Data on the upstream side,
// valid/ready/level on the synchronous consumer side.
interface hs_token_sink_if
  import ddp_hs_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);

  localparam int LW = ptrWidth(DEPTH);

  logic              Send_in;
  logic [DATA_W-1:0] Data_in;
  logic              Ack_out;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [LW-1:0]     level;

  modport master (
    output Send_in, Data_in, dout_ready,
    input  Ack_out, dout, dout_valid, level
  );

  modport slave (
    input  Send_in, Data_in, dout_ready,
    output Ack_out, dout, dout_valid, level
  );

endinterface

// File: rtl/hs_token_sink_sync2.sv
// Two-flop synchronizer with async active-low reset to a configurable idle level.
module hs_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hs_token_sink.sv
// Clocked tail of a 4-phase async pipeline: synchronizes Send, captures bundled data into a FIFO.
// Optional statistics outputs (tok_cnt, stall) are built when HS_SINK_STATS_EN is defined.
module hs_token_sink
  import ddp_hs_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic           CLK,
  input  logic           MR_n,
  hs_token_sink_if.slave hs
`ifdef HS_SINK_STATS_EN
  ,
  output logic [31:0]    tok_cnt,
  output logic           stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptrWidth(DEPTH);

  hs_state_t         state_q, state_d;
  logic              ackOut_q;
  logic              sendS;
  logic [PW-1:0]     wrPtr_q, rdPtr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] lastDout_q;
  logic              full, empty, pop, push, room;

  hs_sync2 #(.RESET_VAL(SEND_IDLE)) uSendSync (
    .clk_i  (CLK),
    .rst_ni (MR_n),
    .d_i    (hs.Send_in),
    .q_o    (sendS)
  );

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign pop   = hs.dout_ready && !empty;
  assign room  = !full || pop;

  // Data_in is written on the same edge that drops Ack, so it is still inside its stable window.
  assign push  = (state_q == IDLE) && (sendS != SEND_IDLE) && room;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (push) state_d = CAPT;
      CAPT:     state_d = WAIT_RTZ;
      WAIT_RTZ: if (sendS == SEND_IDLE) state_d = room ? IDLE : HOLD;
      HOLD:     if (room) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state_q  <= IDLE;
      ackOut_q <= ACK_READY;
    end else begin
      state_q  <= state_d;
      ackOut_q <= (state_d == IDLE) ? ACK_READY : ~ACK_READY;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= hs.Data_in;
  end

  // The last popped word is kept so dout stays put while the FIFO is empty.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      lastDout_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop) begin
        rdPtr_q    <= rdPtr_q + PW'(1);
        lastDout_q <= mem_q[rdPtr_q[AW-1:0]];
      end
    end
  end

  assign hs.Ack_out    = ackOut_q;
  assign hs.dout_valid = !empty;
  assign hs.dout       = empty ? lastDout_q : mem_q[rdPtr_q[AW-1:0]];
  assign hs.level      = wrPtr_q - rdPtr_q;

`ifdef HS_SINK_STATS_EN
  logic [31:0] tokCnt_q;

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) tokCnt_q <= '0;
    else if (state_q == CAPT) tokCnt_q <= tokCnt_q + 32'd1;
  end

  assign tok_cnt = tokCnt_q;
  assign stall   = (state_q == HOLD) || ((state_q == IDLE) && (sendS != SEND_IDLE) && !room);
`endif

endmodule

// File: tb/tb_hs_token_sink.sv
// Self-checking bench for hs_token_sink: per-cycle vector table, directed handshake corners,
// and randomized 4-phase traffic checked against a token-queue scoreboard.
module tb_hs_token_sink;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int NRAND  = 300;

  logic CLK = 1'b0;
  logic MR_n;
  always #5 CLK = ~CLK;

  hs_token_sink_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) hsIf ();

`ifdef HS_SINK_STATS_EN
  logic [31:0] tokCnt;
  logic        stall;
`endif

  hs_token_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .MR_n (MR_n),
    .hs   (hsIf)
`ifdef HS_SINK_STATS_EN
    ,
    .tok_cnt (tokCnt),
    .stall   (stall)
`endif
  );

  typedef struct {
    logic              send;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              expAck;
    logic              expValid;
    logic [LW-1:0]     expLevel;
    logic [DATA_W-1:0] expDout;
  } vec_t;

  int                checks   = 0;
  int                failures = 0;
  int                tokensAcked = 0;
  logic [DATA_W-1:0] expQ [$];
  logic [DATA_W-1:0] sentData = '0;
  logic [DATA_W-1:0] lastPopped = '0;
  vec_t              vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with the currently driven inputs; the scoreboard follows tokens by Ack falls and pops.
  task automatic applyStimulus();
    logic              prevAck, prevValid, prevReady;
    logic [DATA_W-1:0] prevDout, head;
    prevAck   = hsIf.Ack_out;
    prevValid = hsIf.dout_valid;
    prevReady = hsIf.dout_ready;
    prevDout  = hsIf.dout;
    @(posedge CLK);
    #1;
    if (prevValid && prevReady) begin
      if (expQ.size() == 0) begin
        checkOutput("popWithNoToken", 32'(expQ.size()), 32'd1);
      end else begin
        head = expQ.pop_front();
        checkOutput("popData", 32'(prevDout), 32'(head));
        lastPopped = head;
      end
    end
    if (prevAck && !hsIf.Ack_out) begin
      expQ.push_back(sentData);
      tokensAcked++;
    end
    checkOutput("level", 32'(hsIf.level), 32'(expQ.size()));
    checkOutput("doutValid", 32'(hsIf.dout_valid), 32'(expQ.size() != 0));
    if (expQ.size() == 0) checkOutput("doutHold", 32'(hsIf.dout), 32'(lastPopped));
`ifdef HS_SINK_STATS_EN
    if (stall) checkOutput("stallOnlyWhenFull", 32'(hsIf.level), 32'(DEPTH));
`endif
  endtask

  task automatic waitAck(input logic val, input int maxCycles, input string name);
    int n = 0;
    while (hsIf.Ack_out !== val && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput(name, 32'(hsIf.Ack_out), 32'(val));
  endtask

  task automatic sendToken(input logic [DATA_W-1:0] d);
    hsIf.Data_in = d;
    sentData     = d;
    hsIf.Send_in = 1'b0;
    waitAck(1'b0, 3, "ackFallLatency");
    hsIf.Data_in = ~d;
    hsIf.Send_in = 1'b1;
    waitAck(1'b1, 3, "ackRiseLatency");
  endtask

  task automatic doReset();
    MR_n            = 1'b0;
    hsIf.Send_in    = 1'b1;
    hsIf.Data_in    = '0;
    hsIf.dout_ready = 1'b0;
    expQ.delete();
    lastPopped  = '0;
    tokensAcked = 0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("inResetAck", 32'(hsIf.Ack_out), 32'd1);
    checkOutput("inResetLevel", 32'(hsIf.level), 32'd0);
    MR_n = 1'b1;
  endtask

  task automatic drain(input string name);
    hsIf.dout_ready = 1'b1;
    for (int i = 0; i < 12 && hsIf.dout_valid; i++) applyStimulus();
    hsIf.dout_ready = 1'b0;
    checkOutput(name, 32'(hsIf.dout_valid), 32'd0);
  endtask

  initial begin
    #3ms;
    $display("[TB] FAIL globalTimeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int phase, gap, started, wd, cyc, raisedAge;
    logic [DATA_W-1:0] d;

    // Reset and idle
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("idleAck", 32'(hsIf.Ack_out), 32'd1);
      checkOutput("idleValid", 32'(hsIf.dout_valid), 32'd0);
      checkOutput("idleLevel", 32'(hsIf.level), 32'd0);
    end

    // Single token 0xA5A5, one row per clock
    vecs[0] = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000};
    vecs[1] = '{1'b0, 16'hA5A5, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000};
    vecs[2] = '{1'b0, 16'hA5A5, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000};
    vecs[3] = '{1'b0, 16'hA5A5, 1'b0, 1'b0, 1'b1, 3'd1, 16'hA5A5};
    vecs[4] = '{1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b1, 3'd1, 16'hA5A5};
    vecs[5] = '{1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b1, 3'd1, 16'hA5A5};
    vecs[6] = '{1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b1, 3'd1, 16'hA5A5};
    vecs[7] = '{1'b1, 16'h5A5A, 1'b1, 1'b1, 1'b0, 3'd0, 16'hA5A5};
    vecs[8] = '{1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b0, 3'd0, 16'hA5A5};
    for (int i = 0; i < 9; i++) begin
      hsIf.Send_in    = vecs[i].send;
      hsIf.Data_in    = vecs[i].data;
      hsIf.dout_ready = vecs[i].ready;
      if (!vecs[i].send) sentData = vecs[i].data;
      applyStimulus();
      checkOutput($sformatf("vecAck[%0d]", i), 32'(hsIf.Ack_out), 32'(vecs[i].expAck));
      checkOutput($sformatf("vecValid[%0d]", i), 32'(hsIf.dout_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vecLevel[%0d]", i), 32'(hsIf.level), 32'(vecs[i].expLevel));
      checkOutput($sformatf("vecDout[%0d]", i), 32'(hsIf.dout), 32'(vecs[i].expDout));
    end

    // Five tokens into a four-entry FIFO with the consumer stalled
    hsIf.dout_ready = 1'b0;
    for (int t = 1; t <= 3; t++) sendToken(DATA_W'(t));
    hsIf.Data_in = 16'd4;
    sentData     = 16'd4;
    hsIf.Send_in = 1'b0;
    waitAck(1'b0, 3, "tok4Fall");
    hsIf.Send_in = 1'b1;
    hsIf.Data_in = 16'hDEAD;
    repeat (4) applyStimulus();
    checkOutput("holdAck", 32'(hsIf.Ack_out), 32'd0);
    checkOutput("holdLevel", 32'(hsIf.level), 32'(DEPTH));
`ifdef HS_SINK_STATS_EN
    checkOutput("holdStall", 32'(stall), 32'd1);
`endif
    checkOutput("order1", 32'(hsIf.dout), 32'd1);
    hsIf.dout_ready = 1'b1;
    applyStimulus();
    hsIf.dout_ready = 1'b0;
    waitAck(1'b1, 3, "holdRelease");
`ifdef HS_SINK_STATS_EN
    checkOutput("stallCleared", 32'(stall), 32'd0);
`endif
    hsIf.Data_in = 16'd5;
    sentData     = 16'd5;
    hsIf.Send_in = 1'b0;
    waitAck(1'b0, 3, "tok5Fall");
    hsIf.Send_in = 1'b1;
    hsIf.Data_in = 16'hBEAD;
    for (int k = 2; k <= 5; k++) begin
      checkOutput($sformatf("order%0d", k), 32'(hsIf.dout), 32'(k));
      hsIf.dout_ready = 1'b1;
      applyStimulus();
    end
    hsIf.dout_ready = 1'b0;
    waitAck(1'b1, 3, "tok5Rise");

    // Push and pop on the same edge, then drain while full and still accepting
    for (int t = 1; t <= 3; t++) sendToken(DATA_W'(t * 16'h11));
    hsIf.Data_in = 16'h44;
    sentData     = 16'h44;
    hsIf.Send_in = 1'b0;
    applyStimulus();
    applyStimulus();
    hsIf.dout_ready = 1'b1;
    applyStimulus();
    hsIf.dout_ready = 1'b0;
    checkOutput("pushPopAck", 32'(hsIf.Ack_out), 32'd0);
    checkOutput("pushPopLevel", 32'(hsIf.level), 32'd3);
    hsIf.Send_in = 1'b1;
    hsIf.Data_in = 16'hFFFF;
    waitAck(1'b1, 3, "pushPopRise");
    hsIf.Data_in = 16'h55;
    sentData     = 16'h55;
    hsIf.Send_in = 1'b0;
    waitAck(1'b0, 3, "fullFall");
    checkOutput("fullLevel", 32'(hsIf.level), 32'(DEPTH));
    hsIf.Send_in    = 1'b1;
    hsIf.dout_ready = 1'b1;
    waitAck(1'b1, 4, "fullDrainRelease");
    sendToken(16'h66);
    drain("drainAfterFull");

    // Reset in WAIT_RTZ with two entries queued; Send stays low through release
    sendToken(16'hBEEF);
    hsIf.Data_in = 16'hCAFE;
    sentData     = 16'hCAFE;
    hsIf.Send_in = 1'b0;
    waitAck(1'b0, 3, "rtzFall");
    applyStimulus();
    checkOutput("preResetLevel", 32'(hsIf.level), 32'd2);
    #2 MR_n = 1'b0;
    #1;
    checkOutput("asyncRstAck", 32'(hsIf.Ack_out), 32'd1);
    checkOutput("asyncRstLevel", 32'(hsIf.level), 32'd0);
    checkOutput("asyncRstValid", 32'(hsIf.dout_valid), 32'd0);
    checkOutput("asyncRstDout", 32'(hsIf.dout), 32'd0);
    expQ.delete();
    lastPopped   = '0;
    hsIf.Data_in = 16'h1234;
    sentData     = 16'h1234;
    repeat (2) @(posedge CLK);
    #1 MR_n = 1'b1;
    waitAck(1'b0, 3, "postRstNewToken");
    checkOutput("postRstData", 32'(hsIf.dout), 32'h1234);
    hsIf.Send_in = 1'b1;
    waitAck(1'b1, 3, "postRstRise");
    drain("drainAfterReset");

    // Randomized 4-phase traffic with random consumer back-pressure
    doReset();
    phase = 0; gap = 0; started = 0; wd = 0; cyc = 0; raisedAge = 0;
    while ((started < NRAND || phase != 0) && cyc < 20000) begin
      hsIf.dout_ready = ($urandom_range(0, 1) == 1);
      case (phase)
        0: if (started < NRAND) begin
             if (gap == 0) begin
               d            = DATA_W'($urandom);
               hsIf.Data_in = d;
               sentData     = d;
               hsIf.Send_in = 1'b0;
               phase = 1; wd = 0; started++;
             end else gap--;
           end
        1: if (!hsIf.Ack_out) begin
             hsIf.Send_in = 1'b1;
             hsIf.Data_in = DATA_W'($urandom);
             phase = 2; wd = 0; raisedAge = 0;
           end
        default: if (hsIf.Ack_out) begin
             phase = 0;
             gap   = $urandom_range(0, 5);
           end
      endcase
      applyStimulus();
      cyc++; wd++;
      if (phase == 2) raisedAge++;
`ifdef HS_SINK_STATS_EN
      if (phase == 2 && raisedAge >= 3 && !hsIf.Ack_out) checkOutput("stallInHold", 32'(stall), 32'd1);
`endif
      if (wd > 200) begin
        checkOutput("randHandshakeTimeout", 32'(wd), 32'd0);
        break;
      end
    end
    checkOutput("randTokensAcked", 32'(tokensAcked), 32'(NRAND));
    drain("randDrain");
    checkOutput("randFinalLevel", 32'(hsIf.level), 32'd0);
`ifdef HS_SINK_STATS_EN
    checkOutput("tokCnt", tokCnt, 32'(tokensAcked));
    checkOutput("tokCntTotal", tokCnt, 32'(NRAND));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
